// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared AXI4-Lite definitions for the SRAM responder.
// Contents: response codes, read/write FSM state enums, delay counter width.
package ysyx_24110015_axi_pkg;

  localparam int DLY_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/ysyx_24110015_axil_sram_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as a random response-delay
// source. Only compiled when YSYX_24110015_RAND_DELAY_EN is defined.
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous active-high reset, loads seed
//   seed  in  8  reset value, must be non-zero
//   q     out 8  current LFSR state, advances every cycle
`ifdef YSYX_24110015_RAND_DELAY_EN
module ysyx_24110015_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= seed;
    else     r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
  end

  assign q = r_q;

endmodule
`endif

// File: rtl/ysyx_24110015_axil_sram.sv
// AXI4-Lite responder wrapping an inferred word SRAM, with independent read
// (AR/R) and write (AW/W/B) FSMs and a programmable per-transaction delay.
// Configuration macro: YSYX_24110015_RAND_DELAY_EN
//   defined   : delay = LFSR & DELAY_MASK, sampled at each AR / write capture
//   undefined : delay = FIXED_DELAY, no LFSR
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
module ysyx_24110015_axil_sram
  import ysyx_24110015_axi_pkg::*;
#(
  parameter int               DEPTH_LOG2  = 12,
  parameter logic [31:0]      BASE_ADDR   = 32'h8000_0000,
  parameter logic [DLY_W-1:0] FIXED_DELAY = 8'd1,
  parameter logic [DLY_W-1:0] DELAY_MASK  = 8'h0F,
  parameter logic [DLY_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  // Offset is relative to BASE_ADDR; addresses below the base wrap to huge
  // offsets and so fall out of range together with those above the top.
  function automatic logic [1:0] decode(input logic [31:0] off);
    if ({1'b0, off} >= SPAN)   return RESP_DECERR;
    if (off[1:0] != 2'b00)     return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // ---------------- delay source ----------------
  logic [DLY_W-1:0] w_delay;
`ifdef YSYX_24110015_RAND_DELAY_EN
  logic [DLY_W-1:0] w_lfsr;
  logic [DLY_W-1:0] w_unused_cfg;
  ysyx_24110015_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (w_lfsr)
  );
  assign w_delay      = w_lfsr & DELAY_MASK;
  assign w_unused_cfg = FIXED_DELAY;
`else
  logic [2*DLY_W-1:0] w_unused_cfg;
  assign w_delay      = FIXED_DELAY;
  assign w_unused_cfg = {DELAY_MASK, LFSR_SEED};
`endif

  logic [31:0] r_mem [DEPTH];

  // ---------------- read path ----------------
  rd_state_t              r_rd_state, w_rd_state_n;
  logic [DLY_W-1:0]       r_rd_cnt;
  logic [DEPTH_LOG2-1:0]  r_rd_idx;
  logic [1:0]             r_rd_resp;
  logic [31:0]            r_rdata;
  logic                   r_arready, r_rvalid;
  logic [31:0]            w_ar_off;
  logic                   w_ar_hs, w_r_hs, w_rd_sample;

  assign w_ar_off = araddr - BASE_ADDR;
  assign w_ar_hs  = arvalid & r_arready;
  assign w_r_hs   = r_rvalid & rready;

  always_comb begin
    w_rd_state_n = r_rd_state;
    w_rd_sample  = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_ar_hs) w_rd_state_n = R_WAIT;
      R_WAIT: if (r_rd_cnt == '0) begin
        w_rd_state_n = R_RESP;
        w_rd_sample  = 1'b1;
      end
      R_RESP: if (w_r_hs) w_rd_state_n = R_IDLE;
      default: w_rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_n;
      r_arready  <= (w_rd_state_n == R_IDLE);
      r_rvalid   <= (w_rd_state_n == R_RESP);
      if (w_ar_hs)                                   r_rd_cnt <= w_delay;
      else if (r_rd_state == R_WAIT && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - 1'b1;
    end
  end

  // Read sample and write commit may hit the same word on the same edge;
  // non-blocking semantics return the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_rd_idx  <= w_ar_off[DEPTH_LOG2+1:2];
      r_rd_resp <= decode(w_ar_off);
    end
    if (w_rd_sample) r_rdata <= (r_rd_resp == RESP_OKAY) ? r_mem[r_rd_idx] : '0;
  end

  // ---------------- write path ----------------
  wr_state_t              r_wr_state, w_wr_state_n;
  logic [DLY_W-1:0]       r_wr_cnt;
  logic [DEPTH_LOG2-1:0]  r_wr_idx;
  logic [1:0]             r_wr_resp;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic                   r_aw_got, r_w_got;
  logic                   r_awready, r_wready, r_bvalid;
  logic [31:0]            w_aw_off;
  logic                   w_aw_hs, w_w_hs, w_b_hs;
  logic                   w_have_aw, w_have_w, w_wr_cap, w_commit;

  assign w_aw_off  = awaddr - BASE_ADDR;
  assign w_aw_hs   = awvalid & r_awready;
  assign w_w_hs    = wvalid & r_wready;
  assign w_b_hs    = r_bvalid & bready;
  assign w_have_aw = r_aw_got | w_aw_hs;
  assign w_have_w  = r_w_got | w_w_hs;

  always_comb begin
    w_wr_state_n = r_wr_state;
    w_wr_cap     = 1'b0;
    w_commit     = 1'b0;
    case (r_wr_state)
      W_IDLE: if (w_have_aw && w_have_w) begin
        w_wr_state_n = W_WAIT;
        w_wr_cap     = 1'b1;
      end
      W_WAIT: if (r_wr_cnt == '0) begin
        w_wr_state_n = W_RESP;
        // a reset on the commit edge must not leave a partial write behind
        w_commit     = (r_wr_resp == RESP_OKAY) && !rst;
      end
      W_RESP: if (w_b_hs) w_wr_state_n = W_IDLE;
      default: w_wr_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_n;
      // each channel stays closed from its own handshake until B completes
      r_aw_got   <= (w_wr_state_n == W_IDLE) && w_have_aw;
      r_w_got    <= (w_wr_state_n == W_IDLE) && w_have_w;
      r_awready  <= (w_wr_state_n == W_IDLE) && !w_have_aw;
      r_wready   <= (w_wr_state_n == W_IDLE) && !w_have_w;
      r_bvalid   <= (w_wr_state_n == W_RESP);
      if (w_wr_cap)                                    r_wr_cnt <= w_delay;
      else if (r_wr_state == W_WAIT && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_wr_idx  <= w_aw_off[DEPTH_LOG2+1:2];
      r_wr_resp <= decode(w_aw_off);
    end
    if (w_w_hs) begin
      r_wdata <= wdata;
      r_wstrb <= wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[r_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- outputs ----------------
  // Everything reads as zero while rst is high, even before the first edge.
  logic w_rvalid_q, w_bvalid_q;
  assign w_rvalid_q = r_rvalid & ~rst;
  assign w_bvalid_q = r_bvalid & ~rst;

  assign arready = r_arready & ~rst;
  assign rvalid  = w_rvalid_q;
  assign rdata   = w_rvalid_q ? r_rdata : '0;
  assign rresp   = w_rvalid_q ? r_rd_resp : '0;
  assign awready = r_awready & ~rst;
  assign wready  = r_wready & ~rst;
  assign bvalid  = w_bvalid_q;
  assign bresp   = w_bvalid_q ? r_wr_resp : '0;

endmodule

// File: tb/tb_ysyx_24110015_axil_sram.sv
module tb_ysyx_24110015_axil_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_24110015_RAND_DELAY_EN
  localparam logic [7:0] TB_MASK = 8'h00;
  localparam int         EXP_LAT = 2;
`else
  localparam logic [7:0] TB_MASK = 8'h0F;
  localparam int         EXP_LAT = 3;
`endif

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  ysyx_24110015_axil_sram #(.DELAY_MASK(TB_MASK)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: plain range arithmetic on the byte address.
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    longint la, lb;
    la = {32'd0, a};
    lb = {32'd0, BASE};
    if (la < lb || la >= lb + 16384) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (s[i]) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp, output int lat,
                           output bit viol);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    viol = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= ((lead > 0) ? lead : 0));
      wvalid  = !w_done  && (cyc >= ((lead < 0) ? -lead : 0));
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); @(negedge clk); cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      awvalid = 0; wvalid = 0;
      if (aw_done && !w_done && awready) viol = 1;
      if (w_done && !aw_done && wready)  viol = 1;
    end
    chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
    bready = 1; lat = 1;
    while (!bvalid && lat < 60) begin
      if (awready || wready) viol = 1;
      @(negedge clk); lat++;
    end
    chk("bvalid_seen", bvalid, 1);
    resp = bresp;
    @(posedge clk); @(negedge clk);
    bready = 0;
    if (bvalid || !awready || !wready) viol = 1;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit viol);
    int cyc = 0;
    bit done = 0, hs;
    viol = 0;
    araddr = a;
    while (!done && cyc < 50) begin
      arvalid = 1;
      hs = arready;
      @(posedge clk); @(negedge clk); cyc++;
      if (hs) done = 1;
    end
    arvalid = 0;
    chk("ar_handshake", done, 1);
    lat = 1;
    while (!rvalid && lat < 60) begin
      if (arready) viol = 1;
      @(negedge clk); lat++;
    end
    chk("rvalid_seen", rvalid, 1);
    data = rdata; resp = rresp;
    for (int k = 0; k < hold; k++) begin
      arvalid = 1; araddr = a ^ 32'h4;
      @(posedge clk); @(negedge clk);
      if (!rvalid || rdata !== data || rresp !== resp || arready) viol = 1;
    end
    arvalid = 0; araddr = a; rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    if (rvalid || !arready) viol = 1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t        tbl[15];
  logic [31:0] rd, model[16];
  logic [1:0]  rs, er;
  int          lat, lat_r, lat_b, n;
  bit          viol, got_r, got_b, seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation stalled, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; araddr = 0; arvalid = 0; rready = 0; awaddr = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wvalid = 0; bready = 0;

    tbl[0]  = '{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00};
    tbl[1]  = '{0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00};
    tbl[2]  = '{1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 2'b00};
    tbl[3]  = '{0, 32'h8000_0010, 32'hDEAD_ABEF, 4'h0, 2'b00};
    tbl[4]  = '{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 2'b11};
    tbl[5]  = '{0, 32'h8000_0002, 32'h0, 4'h0, 2'b10};
    tbl[6]  = '{1, 32'h8000_0000, 32'h1234_5678, 4'hF, 2'b00};
    tbl[7]  = '{1, 32'h8001_0000, 32'hFFFF_FFFF, 4'hF, 2'b11};
    tbl[8]  = '{0, 32'h8000_0000, 32'h1234_5678, 4'h0, 2'b00};
    tbl[9]  = '{1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 2'b10};
    tbl[10] = '{0, 32'h8000_0010, 32'hDEAD_ABEF, 4'h0, 2'b00};
    tbl[11] = '{1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00};
    tbl[12] = '{0, 32'h8000_3FFC, 32'hCAFE_F00D, 4'h0, 2'b00};
    tbl[13] = '{0, 32'h8000_4000, 32'h0, 4'h0, 2'b11};
    tbl[14] = '{1, 32'h8000_3FFE, 32'h0, 4'hF, 2'b10};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("outputs_in_reset", {arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp}, 0);
    rst = 0;
    chk("arready_at_release", arready, 0);
    @(posedge clk); @(negedge clk);
    chk("readies_after_release", {arready, awready, wready}, 3'b111);

    // directed table
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, rs, lat, viol);
      end else begin
        axi_read(tbl[i].addr, 0, rd, rs, lat, viol);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].data);
      end
      chk($sformatf("tbl%0d_resp", i), rs, tbl[i].resp);
      chk($sformatf("tbl%0d_latency", i), lat, EXP_LAT);
      chk($sformatf("tbl%0d_protocol", i), viol, 0);
    end

    // W leads AW by 3 cycles, then AW leads W by 2
    axi_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 3, rs, lat, viol);
    chk("wlead_resp", rs, 2'b00);
    chk("wlead_wready_low", viol, 0);
    axi_write(32'h8000_0044, 32'h600D_CAFE, 4'hF, -2, rs, lat, viol);
    chk("awlead_protocol", viol, 0);
    axi_read(32'h8000_0040, 0, rd, rs, lat, viol);
    chk("wlead_data", rd, 32'h0BAD_F00D);
    axi_read(32'h8000_0044, 0, rd, rs, lat, viol);
    chk("awlead_data", rd, 32'h600D_CAFE);

    // rready held low for 5 cycles
    axi_read(32'h8000_0010, 5, rd, rs, lat, viol);
    chk("hold_rdata", rd, 32'hDEAD_ABEF);
    chk("hold_stable_no_ar", viol, 0);

    // same-edge read sample and write commit to one word
    axi_write(32'h8000_0020, 32'h1111_1111, 4'hF, 0, rs, lat, viol);
    awaddr = 32'h8000_0020; araddr = 32'h8000_0020; wdata = 32'h2222_2222; wstrb = 4'hF;
    chk("rbw_readies", {arready, awready, wready}, 3'b111);
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; bready = 1;
    got_r = 0; got_b = 0; n = 0; lat_r = 0; lat_b = 0; rd = 0;
    while (!(got_r && got_b) && n < 40) begin
      if (rvalid && !got_r) begin got_r = 1; rd = rdata; lat_r = n + 1; end
      if (bvalid && !got_b) begin got_b = 1; lat_b = n + 1; end
      if (!(got_r && got_b)) begin @(negedge clk); n++; end
    end
    @(posedge clk); @(negedge clk);
    rready = 0; bready = 0;
    chk("rbw_old_data", rd, 32'h1111_1111);
    chk("rbw_read_latency", lat_r, EXP_LAT);
    chk("rbw_write_latency", lat_b, EXP_LAT);
    axi_read(32'h8000_0020, 0, rd, rs, lat, viol);
    chk("rbw_new_data", rd, 32'h2222_2222);

    // reset while a read waits
    araddr = 32'h8000_0010; arvalid = 1;
    @(posedge clk); @(negedge clk);
    arvalid = 0; rst = 1; rready = 1;
    @(posedge clk); @(negedge clk);
    chk("outputs_mid_reset", {arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp}, 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
    chk("arready_at_release2", arready, 0);
    @(posedge clk); @(negedge clk);
    chk("arready_after_release2", arready, 1);
    seen = 0;
    repeat (6) begin
      if (rvalid) seen = 1;
      @(posedge clk); @(negedge clk);
    end
    rready = 0;
    chk("no_rvalid_after_abort", seen, 0);

    // reset while a write waits: nothing committed, no bvalid
    axi_write(32'h8000_0050, 32'h55AA_55AA, 4'hF, 0, rs, lat, viol);
    awaddr = 32'h8000_0050; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; rst = 1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 0; bready = 1;
    seen = 0;
    repeat (6) begin
      if (bvalid) seen = 1;
      @(posedge clk); @(negedge clk);
    end
    bready = 0;
    chk("no_bvalid_after_abort", seen, 0);
    axi_read(32'h8000_0050, 0, rd, rs, lat, viol);
    chk("aborted_write_not_committed", rd, 32'h55AA_55AA);

    // randomized traffic against the array model
    for (int k = 0; k < 16; k++) begin
      model[k] = $urandom;
      axi_write(BASE + 32'h100 + 32'(4 * k), model[k], 4'hF, 0, rs, lat, viol);
      chk("rnd_init_resp", rs, 2'b00);
    end
    for (int it = 0; it < 60; it++) begin
      int k, kind, lead, hold;
      logic [31:0] a, d;
      logic [3:0]  s;
      k    = $urandom_range(15, 0);
      kind = $urandom_range(7, 0);
      a    = BASE + 32'h100 + 32'(4 * k);
      if (kind == 0)      a = a + 32'($urandom_range(3, 1));
      else if (kind == 1) a = BASE - 32'(4 * (k + 1));
      else if (kind == 2) a = BASE + 32'h4000 + 32'(4 * k);
      er = exp_resp(a);
      if ($urandom_range(1, 0) == 1) begin
        d    = $urandom;
        s    = 4'($urandom_range(15, 0));
        lead = $urandom_range(6, 0) - 3;
        axi_write(a, d, s, lead, rs, lat, viol);
        chk($sformatf("rnd%0d_bresp", it), rs, er);
        if (er == 2'b00) model[k] = merge(model[k], d, s);
      end else begin
        hold = $urandom_range(2, 0);
        axi_read(a, hold, rd, rs, lat, viol);
        chk($sformatf("rnd%0d_rresp", it), rs, er);
        chk($sformatf("rnd%0d_rdata", it), rd, (er == 2'b00) ? model[k] : 32'h0);
      end
      chk($sformatf("rnd%0d_latency", it), lat, EXP_LAT);
      chk($sformatf("rnd%0d_protocol", it), viol, 0);
    end
    for (int k = 0; k < 16; k++) begin
      axi_read(BASE + 32'h100 + 32'(4 * k), 0, rd, rs, lat, viol);
      chk($sformatf("final_word%0d", k), rd, model[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
